// File: rtl/guess_pkg.sv
// Shared types and constants for the Mastermind-style guess checker.
package guess_pkg;

    // Game phases: waiting for a first load, collecting digits, the two
    // scoring passes, and the sticky game-over phase.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ENTRY     = 3'd1,
        CHK_EXACT = 3'd2,
        CHK_PART  = 3'd3,
        OVER      = 3'd4
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_BLANK  = 4'hF;
    localparam int     NUM_DIGITS = 4;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector for a button level.
// The output is a one-cycle pulse, one clock after the input is first seen high.
module edge_rise (
    input  logic CLK,
    input  logic RST_N,
    input  logic in,
    output logic rise
);

    logic prev;

    // Remember the previous level and flag a 0->1 transition as a registered pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= in;
            rise <= in & ~prev;
        end
    end

endmodule

// File: rtl/guess_checker.sv
// Mastermind-style game core: latches a four-digit secret, collects four BCD
// guess digits, scores them sequentially (exact pass, then misplaced pass),
// and tracks attempts until a win or a loss.
module guess_checker
    import guess_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LOAD,
    input  logic [3:0] SECRET_1,
    input  logic [3:0] SECRET_2,
    input  logic [3:0] SECRET_3,
    input  logic [3:0] SECRET_4,
    input  logic [3:0] DIGIT,
    input  logic       ENTER,
    input  logic       CLEAR,
    output logic [3:0] GUESS_1,
    output logic [3:0] GUESS_2,
    output logic [3:0] GUESS_3,
    output logic [3:0] GUESS_4,
    output logic [2:0] EXACT,
    output logic [2:0] PARTIAL,
    output logic       RESULT_VALID,
    output logic [3:0] TRIES,
    output logic       BUSY,
    output logic       ERR,
    output logic       WIN,
    output logic       LOSE
);

    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

    logic load_rise;
    logic enter_rise;
    logic clear_rise;

    edge_rise u_load_edge  (.CLK(CLK), .RST_N(RST_N), .in(LOAD),  .rise(load_rise));
    edge_rise u_enter_edge (.CLK(CLK), .RST_N(RST_N), .in(ENTER), .rise(enter_rise));
    edge_rise u_clear_edge (.CLK(CLK), .RST_N(RST_N), .in(CLEAR), .rise(clear_rise));

    state_t     state;
    digit_t     secret [NUM_DIGITS];
    digit_t     guess  [NUM_DIGITS];
    logic [2:0] entry_cnt;
    logic [4:0] idx;
    logic [2:0] exact_acc;
    logic [2:0] part_acc;
    logic [3:0] used_s;
    logic [3:0] used_g;
    logic [2:0] exact_q;
    logic [2:0] part_q;
    logic [3:0] tries_q;
    logic       valid_q;
    logic       err_q;
    logic       win_q;
    logic       lose_q;

    logic [1:0] gi;
    logic [1:0] sj;
    logic [3:0] tries_inc;
    logic       enter_live;

    // Split the scan index into guess/secret positions and precompute the
    // saturating attempt count; an ENTER that loses to CLEAR is swallowed.
    always_comb begin
        gi         = idx[3:2];
        sj         = idx[1:0];
        tries_inc  = (tries_q < TRY_LIMIT) ? tries_q + 4'd1 : tries_q;
        enter_live = enter_rise & ~clear_rise;
    end

    // Game FSM with guess buffer, scoring accumulators and attempt tracking.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            entry_cnt <= 3'd0;
            idx       <= 5'd0;
            exact_acc <= 3'd0;
            part_acc  <= 3'd0;
            used_s    <= 4'd0;
            used_g    <= 4'd0;
            exact_q   <= 3'd0;
            part_q    <= 3'd0;
            tries_q   <= 4'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                secret[k] <= 4'd0;
                guess[k]  <= DIG_BLANK;
            end
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (load_rise) begin
                secret[0] <= SECRET_1;
                secret[1] <= SECRET_2;
                secret[2] <= SECRET_3;
                secret[3] <= SECRET_4;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    guess[k] <= DIG_BLANK;
                end
                entry_cnt <= 3'd0;
                idx       <= 5'd0;
                exact_acc <= 3'd0;
                part_acc  <= 3'd0;
                used_s    <= 4'd0;
                used_g    <= 4'd0;
                exact_q   <= 3'd0;
                part_q    <= 3'd0;
                tries_q   <= 4'd0;
                win_q     <= 1'b0;
                lose_q    <= 1'b0;
                state     <= ENTRY;
            end else begin
                case (state)
                    ENTRY: begin
                        if (clear_rise) begin
                            for (int k = 0; k < NUM_DIGITS; k++) begin
                                guess[k] <= DIG_BLANK;
                            end
                            entry_cnt <= 3'd0;
                        end else if (enter_rise) begin
                            if (DIGIT > 4'd9) begin
                                err_q <= 1'b1;
                            end else begin
                                guess[entry_cnt[1:0]] <= DIGIT;
                                entry_cnt             <= entry_cnt + 3'd1;
                                if (entry_cnt == 3'd3) begin
                                    idx       <= 5'd0;
                                    exact_acc <= 3'd0;
                                    part_acc  <= 3'd0;
                                    used_s    <= 4'd0;
                                    used_g    <= 4'd0;
                                    state     <= CHK_EXACT;
                                end
                            end
                        end
                    end
                    CHK_EXACT: begin
                        if (enter_live) begin
                            err_q <= 1'b1;
                        end
                        if (guess[sj] == secret[sj]) begin
                            exact_acc  <= exact_acc + 3'd1;
                            used_s[sj] <= 1'b1;
                            used_g[sj] <= 1'b1;
                        end
                        if (idx == 5'd3) begin
                            idx   <= 5'd0;
                            state <= CHK_PART;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                    CHK_PART: begin
                        if (enter_live) begin
                            err_q <= 1'b1;
                        end
                        if (idx == 5'd16) begin
                            exact_q <= exact_acc;
                            part_q  <= part_acc;
                            valid_q <= 1'b1;
                            tries_q <= tries_inc;
                            idx     <= 5'd0;
                            if (exact_acc == 3'd4) begin
                                win_q <= 1'b1;
                                state <= OVER;
                            end else if (tries_inc == TRY_LIMIT) begin
                                lose_q <= 1'b1;
                                state  <= OVER;
                            end else begin
                                for (int k = 0; k < NUM_DIGITS; k++) begin
                                    guess[k] <= DIG_BLANK;
                                end
                                entry_cnt <= 3'd0;
                                state     <= ENTRY;
                            end
                        end else begin
                            if (!used_g[gi] && !used_s[sj] && guess[gi] == secret[sj]) begin
                                part_acc   <= part_acc + 3'd1;
                                used_g[gi] <= 1'b1;
                                used_s[sj] <= 1'b1;
                            end
                            idx <= idx + 5'd1;
                        end
                    end
                    OVER: begin
                        if (enter_live) begin
                            err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign GUESS_1      = guess[0];
    assign GUESS_2      = guess[1];
    assign GUESS_3      = guess[2];
    assign GUESS_4      = guess[3];
    assign EXACT        = exact_q;
    assign PARTIAL      = part_q;
    assign RESULT_VALID = valid_q;
    assign TRIES        = tries_q;
    assign BUSY         = (state == CHK_EXACT) || (state == CHK_PART);
    assign ERR          = err_q;
    assign WIN          = win_q;
    assign LOSE         = lose_q;

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker: a game-level model tracks what every
// output must be each cycle, and directed scenarios pin literal expectations.
module tb_guess_checker;

    localparam int MAX_TRIES = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, enter, clear;
    logic [3:0] secret_1, secret_2, secret_3, secret_4;
    logic [3:0] digit;
    logic [3:0] guess_1, guess_2, guess_3, guess_4;
    logic [2:0] exact, partial;
    logic       result_valid, busy, err, win, lose;
    logic [3:0] tries;

    always #5 clk = ~clk;

    guess_checker #(.MAX_TRIES(MAX_TRIES)) dut (
        .CLK(clk), .RST_N(rst_n), .LOAD(load),
        .SECRET_1(secret_1), .SECRET_2(secret_2), .SECRET_3(secret_3), .SECRET_4(secret_4),
        .DIGIT(digit), .ENTER(enter), .CLEAR(clear),
        .GUESS_1(guess_1), .GUESS_2(guess_2), .GUESS_3(guess_3), .GUESS_4(guess_4),
        .EXACT(exact), .PARTIAL(partial), .RESULT_VALID(result_valid), .TRIES(tries),
        .BUSY(busy), .ERR(err), .WIN(win), .LOSE(lose)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Game-level model: phase 0 idle, 1 entry, 2 scoring, 3 over.
    int m_phase;
    int m_sec [4];
    int m_gs  [4];
    int m_cnt, m_exact, m_part, m_tries, m_timer;
    bit m_win, m_lose, m_valid, m_err;

    task automatic check_output(input string name, input logic [7:0] act, input int exp);
        logic [7:0] e;
        e = 8'(exp);
        total++;
        if (act !== e) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, e, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_cnt = 0; m_exact = 0; m_part = 0; m_tries = 0; m_timer = 0;
        m_win = 0; m_lose = 0; m_valid = 0; m_err = 0;
        for (int k = 0; k < 4; k++) begin m_sec[k] = 0; m_gs[k] = 15; end
    endfunction

    function automatic void model_load(input bit [15:0] s);
        m_sec[0] = int'(s[15:12]); m_sec[1] = int'(s[11:8]);
        m_sec[2] = int'(s[7:4]);   m_sec[3] = int'(s[3:0]);
        for (int k = 0; k < 4; k++) m_gs[k] = 15;
        m_cnt = 0; m_exact = 0; m_part = 0; m_tries = 0; m_timer = 0;
        m_win = 0; m_lose = 0; m_valid = 0; m_phase = 1;
    endfunction

    // Standard score: exact by position, total common digits by per-digit min counts.
    function automatic void model_result();
        int cs [10];
        int cg [10];
        int ex, common;
        ex = 0; common = 0;
        for (int d = 0; d < 10; d++) begin cs[d] = 0; cg[d] = 0; end
        for (int k = 0; k < 4; k++) begin
            if (m_gs[k] == m_sec[k]) ex++;
            cs[m_sec[k]]++;
            cg[m_gs[k]]++;
        end
        for (int d = 0; d < 10; d++) common += (cs[d] < cg[d]) ? cs[d] : cg[d];
        m_exact = ex;
        m_part  = common - ex;
        m_valid = 1;
        if (m_tries < MAX_TRIES) m_tries++;
        if (ex == 4) begin
            m_win = 1; m_phase = 3;
        end else if (m_tries >= MAX_TRIES) begin
            m_lose = 1; m_phase = 3;
        end else begin
            for (int k = 0; k < 4; k++) m_gs[k] = 15;
            m_cnt = 0; m_phase = 1;
        end
    endfunction

    function automatic void model_enter(input int d, input int ph);
        if (ph == 0) return;
        if (ph != 1 || d > 9) begin
            m_err = 1;
            return;
        end
        m_gs[m_cnt] = d;
        m_cnt++;
        if (m_cnt == 4) begin
            m_phase = 2;
            m_timer = 21;
        end
    endfunction

    // One clock: advance the model past the edge, then apply any button action due at it.
    task automatic cycle(input bit ld, input bit en, input bit cl, input logic [3:0] d, input bit [15:0] s);
        int ph;
        @(posedge clk);
        #1;
        ph = m_phase;
        m_valid = 0;
        m_err   = 0;
        if (m_timer > 0) begin
            m_timer--;
            if (m_timer == 0) model_result();
        end
        if (ld) begin
            model_load(s);
        end else if (cl) begin
            if (ph == 1) begin
                for (int k = 0; k < 4; k++) m_gs[k] = 15;
                m_cnt = 0;
            end
        end else if (en) begin
            model_enter(int'(d), ph);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    // Press buttons for one cycle; the action lands two edges after they rise.
    task automatic apply_stimulus(input bit ld, input bit en, input bit cl, input logic [3:0] d, input bit [15:0] s);
        if (ld) begin
            secret_1 = s[15:12]; secret_2 = s[11:8]; secret_3 = s[7:4]; secret_4 = s[3:0];
        end
        digit = d;
        load = ld; enter = en; clear = cl;
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        load = 1'b0; enter = 1'b0; clear = 1'b0;
        cycle(ld, en, cl, d, s);
    endtask

    task automatic do_load(input bit [15:0] s);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, s);
    endtask

    task automatic do_guess(input bit [15:0] g);
        apply_stimulus(1'b0, 1'b1, 1'b0, g[15:12], 16'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, g[11:8],  16'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, g[7:4],   16'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, g[3:0],   16'd0);
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
            if (result_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check_output("result_timeout", 8'd0, 1);
    endtask

    // Every cycle, compare all outputs with the game model.
    always @(negedge clk) begin
        if (chk_en) begin
            check_output("cyc_guess1", 8'(guess_1), m_gs[0]);
            check_output("cyc_guess2", 8'(guess_2), m_gs[1]);
            check_output("cyc_guess3", 8'(guess_3), m_gs[2]);
            check_output("cyc_guess4", 8'(guess_4), m_gs[3]);
            check_output("cyc_exact",   8'(exact),   m_exact);
            check_output("cyc_partial", 8'(partial), m_part);
            check_output("cyc_tries",   8'(tries),   m_tries);
            check_output("cyc_valid",   8'(result_valid), int'(m_valid));
            check_output("cyc_err",     8'(err),     int'(m_err));
            check_output("cyc_busy",    8'(busy),    (m_timer > 0) ? 1 : 0);
            check_output("cyc_win",     8'(win),     int'(m_win));
            check_output("cyc_lose",    8'(lose),    int'(m_lose));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bit [15:0] s;
        int r;
        rst_n = 1'b0;
        load = 1'b0; enter = 1'b0; clear = 1'b0; digit = 4'd0;
        secret_1 = 4'd0; secret_2 = 4'd0; secret_3 = 4'd0; secret_4 = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_guess1", 8'(guess_1), 15);
        check_output("rst_guess4", 8'(guess_4), 15);
        check_output("rst_exact",  8'(exact),   0);
        check_output("rst_tries",  8'(tries),   0);
        check_output("rst_busy",   8'(busy),    0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        idle_cycles(2);

        // Idle ignores ENTER entirely.
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd3, 16'd0);
        check_output("idle_enter_guess1", 8'(guess_1), 15);

        // Secret 1234, guess 1234: win on the first try, fixed latency.
        do_load(16'h1234);
        do_guess(16'h1234);
        wait_result(lat);
        check_output("win_latency", 8'(lat), 21);
        check_output("win_exact",   8'(exact),   4);
        check_output("win_partial", 8'(partial), 0);
        check_output("win_flag",    8'(win),     1);
        check_output("win_tries",   8'(tries),   1);

        // Duplicate-aware scoring.
        do_load(16'h1123);
        do_guess(16'h3111);
        wait_result(lat);
        check_output("dup1_exact",   8'(exact),   1);
        check_output("dup1_partial", 8'(partial), 2);
        do_load(16'h5555);
        do_guess(16'h5005);
        wait_result(lat);
        check_output("dup2_exact",   8'(exact),   2);
        check_output("dup2_partial", 8'(partial), 0);

        // Eight misses lose the game; ENTER afterwards only pulses ERR.
        do_load(16'h1234);
        for (int g = 0; g < MAX_TRIES; g++) begin
            do_guess(16'h5678);
            wait_result(lat);
            check_output("miss_exact",   8'(exact),   0);
            check_output("miss_partial", 8'(partial), 0);
        end
        check_output("lose_flag",  8'(lose),  1);
        check_output("lose_tries", 8'(tries), 8);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd7, 16'd0);
        check_output("over_err",    8'(err),     1);
        check_output("over_guess1", 8'(guess_1), 5);

        // Bad digit and CLEAR behaviour.
        do_load(16'h2468);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd12, 16'd0);
        check_output("bad_digit_err",    8'(err),     1);
        check_output("bad_digit_guess1", 8'(guess_1), 15);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd3, 16'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd7, 16'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'd0, 16'd0);
        check_output("clear_guess1", 8'(guess_1), 15);
        check_output("clear_guess2", 8'(guess_2), 15);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd9, 16'd0);
        check_output("restart_guess1", 8'(guess_1), 9);

        // CLEAR and ENTER together: CLEAR wins, no ERR.
        apply_stimulus(1'b0, 1'b1, 1'b1, 4'd4, 16'd0);
        check_output("clr_enter_guess1", 8'(guess_1), 15);
        check_output("clr_enter_err",    8'(err),     0);

        // LOAD ten cycles into scoring aborts the guess.
        do_load(16'h9876);
        do_guess(16'h9876);
        idle_cycles(8);
        do_load(16'h1357);
        idle_cycles(30);
        check_output("abort_tries", 8'(tries), 0);
        check_output("abort_busy",  8'(busy),  0);
        do_guess(16'h1357);
        wait_result(lat);
        check_output("abort_new_exact", 8'(exact), 4);

        // Asynchronous reset in the middle of the misplaced-match pass.
        do_load(16'h1234);
        do_guess(16'h1243);
        wait_result(lat);
        check_output("pre_rst_exact",   8'(exact),   2);
        check_output("pre_rst_partial", 8'(partial), 2);
        do_guess(16'h1111);
        idle_cycles(10);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_busy",    8'(busy),    0);
        check_output("arst_guess4",  8'(guess_4), 15);
        check_output("arst_exact",   8'(exact),   0);
        check_output("arst_partial", 8'(partial), 0);
        check_output("arst_tries",   8'(tries),   0);
        model_reset();
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd5, 16'd0);
        check_output("arst_idle_guess1", 8'(guess_1), 15);
        check_output("arst_idle_err",    8'(err),     0);

        // Randomized play checked cycle by cycle against the model.
        do_load(16'h4321);
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            s = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (r < 4) begin
                do_load(s);
            end else if (r < 10) begin
                apply_stimulus(1'b0, 1'b0, 1'b1, 4'd0, 16'd0);
            end else if (r < 14) begin
                apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), s);
            end else if (r < 20) begin
                apply_stimulus(1'b0, 1'b1, 1'b0, 4'($urandom_range(10, 15)), 16'd0);
            end else begin
                apply_stimulus(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 9)), 16'd0);
            end
            idle_cycles(int'($urandom_range(0, 3)));
        end
        idle_cycles(30);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
